sb_rx_deframer: RTL

SB_RX_DEFRAMER -- requirements
Module: sb_rx_deframer

---
 rtl/sb_pkg.sv | 29 ++
 rtl/sb_crc16.sv | 48 ++++
 rtl/sb_rx_deframer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// Shared sideband framing symbols, deframer state encoding and CRC-16 constants.
package sb_pkg;

    localparam logic [7:0]  DLE     = 8'hFE;
    localparam logic [7:0]  STX_CMD = 8'h05;
    localparam logic [7:0]  STX_RSP = 8'h04;
    localparam logic [7:0]  ETX     = 8'h40;
    localparam logic [3:0]  LSE_HI  = 4'h8;

    localparam logic [15:0] CRC_POLY = 16'h8005;
    localparam logic [15:0] CRC_SEED = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GOT_DLE,
        ST_LT_CHK,
        ST_PAYLOAD,
        ST_PAY_DLE
    } state_t;

    function automatic logic is_stx(input logic [7:0] b);
        return (b == STX_CMD) || (b == STX_RSP);
    endfunction

    function automatic logic is_lse(input logic [7:0] b);
        return b[7:4] == LSE_HI;
    endfunction

endpackage

// File: rtl/sb_crc16.sv
// Byte-wise CRC-16 (CRC_POLY/CRC_SEED), data bit 0 shifted in first, no final XOR.
// Latency: crc reflects a byte presented with en one cycle later.
// Backpressure: none; a byte is absorbed on every cycle en is high.
module sb_crc16
    import sb_pkg::*;
(
    input  logic        sb_clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic [15:0] crc_base;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[15] ^ d[i]) begin
                r = {r[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                r = {r[14:0], 1'b0};
            end
        end
        return r;
    endfunction

    // init reseeds before the same-cycle byte, so a frame's STX is folded in directly
    always_comb begin
        crc_base = init ? CRC_SEED : crc_q;
        crc_d    = en ? crc_step(crc_base, data_in) : crc_base;
    end

    always_ff @(posedge sb_clk) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sb_rx_deframer.sv
// Sideband RX deframer: DLE-unstuffs frames, strips CRC via a 2-byte hold, decodes link transactions.
// Latency: all strobes registered, one cycle after the causing byte; CRC check needs SB_DEFRAMER_CRC_EN.
// Backpressure: none; accepts a byte every cycle byte_valid is high.
module sb_rx_deframer
    import sb_pkg::*;
#(
    parameter int MAX_LEN = 64
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    output logic       pkt_sop,
    output logic       pkt_type,
    output logic       pkt_done,
    output logic       pkt_crc_ok,
    output logic [6:0] pkt_len,
    output logic       lt_valid,
    output logic [7:0] lt_lse,
    output logic       frame_err
);

    localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);

    state_t     state_q, state_d;
    logic [7:0] hold0_q, hold0_d;
    logic [7:0] hold1_q, hold1_d;
    logic [1:0] hold_cnt_q, hold_cnt_d;
    logic [6:0] len_q, len_d;
    logic       type_q, type_d;
    logic [7:0] lse_q, lse_d;
    logic [7:0] pkt_data_q, pkt_data_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic       pkt_sop_q, pkt_sop_d;
    logic       pkt_done_q, pkt_done_d;
    logic [6:0] pkt_len_q, pkt_len_d;
    logic       lt_valid_q, lt_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       start_frame;
    logic       data_byte;
    logic       emit;

    always_comb begin
        state_d     = state_q;
        hold0_d     = hold0_q;
        hold1_d     = hold1_q;
        hold_cnt_d  = hold_cnt_q;
        len_d       = len_q;
        type_d      = type_q;
        lse_d       = lse_q;
        pkt_data_d  = pkt_data_q;
        pkt_valid_d = 1'b0;
        pkt_sop_d   = 1'b0;
        pkt_done_d  = 1'b0;
        pkt_len_d   = pkt_len_q;
        lt_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        start_frame = 1'b0;
        data_byte   = 1'b0;
        emit        = 1'b0;

        if (byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_in == DLE) state_d = ST_GOT_DLE;
                end
                ST_GOT_DLE: begin
                    if (is_stx(byte_in)) begin
                        start_frame = 1'b1;
                    end else if (is_lse(byte_in)) begin
                        lse_d   = byte_in;
                        state_d = ST_LT_CHK;
                    end else if (byte_in != DLE) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LT_CHK: begin
                    if (byte_in == ~lse_q) lt_valid_d  = 1'b1;
                    else                   frame_err_d = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_PAYLOAD: begin
                    if (byte_in == DLE) state_d = ST_PAY_DLE;
                    else                data_byte = 1'b1;
                end
                ST_PAY_DLE: begin
                    if (byte_in == DLE) begin
                        data_byte = 1'b1;
                        state_d   = ST_PAYLOAD;
                    end else if (byte_in == ETX) begin
                        if (hold_cnt_q == 2'd2) begin
                            pkt_done_d = 1'b1;
                            pkt_len_d  = len_q;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else if (is_stx(byte_in)) begin
                        frame_err_d = 1'b1;
                        start_frame = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (start_frame) begin
            state_d    = ST_PAYLOAD;
            type_d     = (byte_in == STX_RSP);
            hold_cnt_d = 2'd0;
            len_d      = 7'd0;
        end

        // The newest two bytes stay held: they are the CRC once ETX arrives
        if (data_byte) begin
            if (hold_cnt_q == 2'd2) begin
                if (len_q == MAX_LEN_W) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    emit        = 1'b1;
                    pkt_valid_d = 1'b1;
                    pkt_data_d  = hold0_q;
                    pkt_sop_d   = (len_q == 7'd0);
                    len_d       = len_q + 7'd1;
                    hold0_d     = hold1_q;
                    hold1_d     = byte_in;
                end
            end else if (hold_cnt_q == 2'd1) begin
                hold1_d    = byte_in;
                hold_cnt_d = 2'd2;
            end else begin
                hold0_d    = byte_in;
                hold_cnt_d = 2'd1;
            end
        end
    end

    always_ff @(posedge sb_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold0_q     <= '0;
            hold1_q     <= '0;
            hold_cnt_q  <= '0;
            len_q       <= '0;
            type_q      <= 1'b0;
            lse_q       <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            pkt_sop_q   <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_len_q   <= '0;
            lt_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
            hold_cnt_q  <= hold_cnt_d;
            len_q       <= len_d;
            type_q      <= type_d;
            lse_q       <= lse_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_sop_q   <= pkt_sop_d;
            pkt_done_q  <= pkt_done_d;
            pkt_len_q   <= pkt_len_d;
            lt_valid_q  <= lt_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef SB_DEFRAMER_CRC_EN
    logic [15:0] crc_val;
    logic        crc_ok_q, crc_ok_d;

    // Received CRC arrives low byte first, so the older held byte is the low half
    sb_crc16 u_crc16 (
        .sb_clk  (sb_clk),
        .rst     (rst),
        .init    (start_frame),
        .en      (start_frame | emit),
        .data_in (start_frame ? byte_in : hold0_q),
        .crc     (crc_val)
    );

    always_comb begin
        crc_ok_d = pkt_done_d ? (crc_val == {hold1_q, hold0_q}) : crc_ok_q;
    end

    always_ff @(posedge sb_clk) begin
        if (rst) begin
            crc_ok_q <= 1'b0;
        end else begin
            crc_ok_q <= crc_ok_d;
        end
    end

    assign pkt_crc_ok = crc_ok_q;
`else
    assign pkt_crc_ok = 1'b1;
`endif

    assign pkt_data  = pkt_data_q;
    assign pkt_valid = pkt_valid_q;
    assign pkt_sop   = pkt_sop_q;
    assign pkt_type  = type_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_len   = pkt_len_q;
    assign lt_valid  = lt_valid_q;
    assign lt_lse    = lse_q;
    assign frame_err = frame_err_q;

endmodule
